// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART encodings for the transmit scheduler and the
//                Uart8 transmitter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_START_TIMEOUT = 32768;

    typedef enum logic [1:0] {
        SCH_DRAIN = 2'd0,
        SCH_IDLE  = 2'd1,
        SCH_START = 2'd2,
        SCH_WAIT  = 2'd3
    } sched_state_t;

    typedef enum logic [2:0] {
        TX_RESET     = 3'd0,
        TX_IDLE      = 3'd1,
        TX_START_BIT = 3'd2,
        TX_DATA_BITS = 3'd3,
        TX_STOP_BIT  = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop single-bit synchroniser into the clk domain.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // No reset: the input is asynchronous and settles within two cycles anyway.
    always_ff @(posedge clk) begin
        r_meta <= i_d;
        r_sync <= r_meta;
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Round-robin arbiter sharing one Uart8 transmitter between
//                NUM_REQ byte producers, tracking each byte to completion.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int NUM_REQ       = 2,
    parameter  int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    localparam int c_id_w        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     reqValid,
    input  logic [8*NUM_REQ-1:0]   reqData,
    output logic [NUM_REQ-1:0]     reqReady,
    output logic                   txEn,
    output logic                   txStart,
    output logic [7:0]             txData,
    input  logic                   txBusy,
    output logic                   byteDone,
    output logic [c_id_w-1:0]      doneId,
    output logic                   err
);

    localparam int                c_to_w    = $clog2(START_TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(START_TIMEOUT - 1);
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NUM_REQ - 1);

    logic              w_busy_s;

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [c_id_w-1:0] r_ptr;
    logic [c_id_w-1:0] w_ptr_nxt;
    logic [c_id_w-1:0] r_grant_id;
    logic [c_id_w-1:0] w_grant_id_nxt;
    logic [c_to_w-1:0] r_cnt;
    logic [c_to_w-1:0] w_cnt_nxt;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_tx_data_nxt;
    logic              r_tx_start;
    logic              w_tx_start_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_tx_en;

    logic              w_any_valid;
    logic [c_id_w-1:0] w_pick;

    sync_2ff u_busy_sync (
        .clk (clk),
        .i_d (txBusy),
        .o_q (w_busy_s)
    );

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin : p_pick
        int v_idx;
        w_any_valid = 1'b0;
        w_pick      = '0;
        v_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!w_any_valid && reqValid[v_idx]) begin
                w_any_valid = 1'b1;
                w_pick      = c_id_w'(v_idx);
            end
        end
    end

    always_comb begin : p_next
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_id_nxt = r_grant_id;
        w_cnt_nxt      = r_cnt;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = r_tx_start;
        w_err_nxt      = r_err;
        reqReady       = '0;
        byteDone       = 1'b0;

        case (r_state)
            SCH_DRAIN: begin
                if (!w_busy_s) begin
                    w_state_nxt = SCH_IDLE;
                end
            end

            SCH_IDLE: begin
                // Handshake outputs are suppressed under reset so no byte is lost.
                if (w_any_valid && !rst) begin
                    reqReady[w_pick] = 1'b1;
                    w_tx_data_nxt    = reqData[8*int'(w_pick) +: 8];
                    w_ptr_nxt        = (w_pick == c_last_id) ? '0 : w_pick + c_id_w'(1);
                    w_grant_id_nxt   = w_pick;
                    w_cnt_nxt        = '0;
                    w_tx_start_nxt   = 1'b1;
                    w_state_nxt      = SCH_START;
                end
            end

            SCH_START: begin
                if (w_busy_s) begin
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = SCH_WAIT;
                end else if (r_cnt == c_to_last) begin
                    w_tx_start_nxt = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = SCH_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + c_to_w'(1);
                end
            end

            SCH_WAIT: begin
                if (!w_busy_s) begin
                    byteDone    = !rst;
                    w_state_nxt = SCH_IDLE;
                end
            end

            default: begin
                w_state_nxt = SCH_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SCH_DRAIN;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_err      <= 1'b0;
            r_tx_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_err      <= w_err_nxt;
            r_tx_en    <= 1'b1;
        end
    end

    assign txEn    = r_tx_en;
    assign txStart = r_tx_start;
    assign txData  = r_tx_data;
    assign doneId  = r_grant_id;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler with a behavioural
//                transmitter, line receiver and round-robin reference model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    localparam int NUM_REQ       = 2;
    localparam int START_TIMEOUT = 128;
    localparam int BIT_CLKS      = 34;

    logic               clk      = 1'b0;
    logic               txclk    = 1'b0;
    logic               rst      = 1'b1;
    logic [NUM_REQ-1:0] reqValid = '0;
    logic [8*NUM_REQ-1:0] reqData = '0;
    logic [NUM_REQ-1:0] reqReady;
    logic               txEn;
    logic               txStart;
    logic [7:0]         txData;
    logic               txBusy;
    logic               byteDone;
    logic [0:0]         doneId;
    logic               err;

    logic               stub       = 1'b0;
    logic               model_busy = 1'b0;
    logic               tx_line    = 1'b1;
    int                 tm_st      = 0;
    int                 tm_bit     = 0;
    logic [7:0]         tm_sh      = 8'h00;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rq [NUM_REQ][$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] rx_log[$];
    int         grant_log[$];
    int         done_log[$];

    int                 ptr          = 0;
    bit                 pending      = 1'b0;
    int                 pend_id      = 0;
    logic [7:0]         pend_data    = 8'h00;
    bit                 just_granted = 1'b0;
    logic [NUM_REQ-1:0] hs           = '0;
    int                 start_run    = 0;
    int                 last_run     = 0;
    bit                 start_fell   = 1'b0;
    bit                 prev_start   = 1'b0;
    int                 done_cnt     = 0;
    int                 rx_bit_idx   = -1;

    assign txBusy = stub ? 1'b0 : model_busy;

    uart_tx_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqReady (reqReady),
        .txEn     (txEn),
        .txStart  (txStart),
        .txData   (txData),
        .txBusy   (txBusy),
        .byteDone (byteDone),
        .doneId   (doneId),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3;
        forever #170 txclk = ~txclk;
    end

    // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit, then idle.
    always @(posedge txclk) begin
        if (!stub) begin
            case (tm_st)
                0: if (txEn && txStart) begin
                       tm_sh      <= txData;
                       model_busy <= 1'b1;
                       tx_line    <= 1'b0;
                       tm_bit     <= 0;
                       tm_st      <= 1;
                   end
                1: begin
                       tx_line <= tm_sh[tm_bit];
                       if (tm_bit == 7) tm_st <= 2;
                       else             tm_bit <= tm_bit + 1;
                   end
                2: begin
                       tx_line <= 1'b1;
                       tm_st   <= 3;
                   end
                default: begin
                       model_busy <= 1'b0;
                       tm_st      <= 0;
                   end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line receiver sampling mid-bit in the clk domain.
    initial begin : p_rx
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge tx_line);
            repeat (BIT_CLKS / 2) @(posedge clk);
            #1;
            chk("rx_start_bit", {31'd0, tx_line}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(posedge clk);
                #1;
                b[i]       = tx_line;
                rx_bit_idx = i;
            end
            repeat (BIT_CLKS) @(posedge clk);
            #1;
            chk("rx_stop_bit", {31'd0, tx_line}, 32'd1);
            rx_bit_idx = -1;
            rx_log.push_back(b);
            if (exp_tx_q.size() != 0) chk("rx_byte", {24'd0, b}, {24'd0, exp_tx_q.pop_front()});
            else                      chk("rx_byte_expected", exp_tx_q.size(), 32'd1);
        end
    end

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic monitor();
        int g;
        if (txStart) begin
            start_run++;
        end else if (prev_start) begin
            last_run   = start_run;
            start_fell = 1'b1;
            start_run  = 0;
        end
        prev_start = txStart;

        if (byteDone) begin
            done_cnt++;
            chk("done_expected", {31'd0, pending}, 32'd1);
            if (pending) begin
                chk("done_id", {31'd0, doneId}, pend_id);
                done_log.push_back(int'(doneId));
                pending = 1'b0;
            end
        end

        if (pending && !just_granted) chk("txdata_stable", {24'd0, txData}, {24'd0, pend_data});
        just_granted = 1'b0;

        if (reqReady != '0) begin
            chk("grant_while_pending", {31'd0, pending}, 32'd0);
            chk("grant_while_line_busy", {31'd0, model_busy}, 32'd0);
            g = rr_pick(reqValid, ptr);
            if (g < 0) begin
                chk("grant_without_valid", {30'd0, reqReady}, 32'd0);
            end else begin
                chk("grant_onehot", {30'd0, reqReady}, 32'd1 << g);
                ptr          = (g + 1) % NUM_REQ;
                hs           = reqReady;
                pending      = 1'b1;
                pend_id      = g;
                pend_data    = reqData[8*g +: 8];
                just_granted = 1'b1;
                grant_log.push_back(g);
                if (!stub) exp_tx_q.push_back(pend_data);
            end
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i] && rq[i].size() > 0) rq[i].delete(0);
            reqValid[i]       = (rq[i].size() > 0);
            reqData[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'($urandom);
        end
        hs = '0;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        apply();
    endtask

    function automatic bit idle_all();
        bit r;
        r = !pending && (exp_tx_q.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !idle_all()) begin
            step();
            n++;
        end
        repeat (4) step();
        chk(tag, {31'd0, idle_all()}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_ready", {30'd0, reqReady}, 32'd0);
        chk("rst_no_done", {31'd0, byteDone}, 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        ptr          = 0;
        pending      = 1'b0;
        just_granted = 1'b0;
        hs           = '0;
        start_run    = 0;
        prev_start   = 1'b0;
        @(negedge clk);
        chk("rst_reqReady", {30'd0, reqReady}, 32'd0);
        chk("rst_txEn",     {31'd0, txEn},     32'd0);
        chk("rst_txStart",  {31'd0, txStart},  32'd0);
        chk("rst_txData",   {24'd0, txData},   32'd0);
        chk("rst_byteDone", {31'd0, byteDone}, 32'd0);
        chk("rst_doneId",   {31'd0, doneId},   32'd0);
        chk("rst_err",      {31'd0, err},      32'd0);
        monitor();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic clear_logs();
        rx_log.delete();
        grant_log.delete();
        done_log.delete();
        done_cnt = 0;
    endtask

    initial begin : p_main
        int n;
        int dc;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Single byte
        clear_logs();
        rq[0].push_back(8'hA5);
        drain(3000, "single_drain");
        chk("single_txEn", {31'd0, txEn}, 32'd1);
        chk("single_done_cnt", done_cnt, 32'd1);
        chk("single_rx_cnt", rx_log.size(), 32'd1);
        chk("single_rx_byte", (rx_log.size() > 0) ? {24'd0, rx_log[0]} : 32'hFFFF, 32'hA5);
        chk("single_done_id", (done_log.size() > 0) ? done_log[0] : -1, 32'd0);

        // Contention from reset
        do_reset();
        clear_logs();
        rq[0].push_back(8'h11);
        rq[1].push_back(8'h22);
        drain(4000, "contend_drain");
        chk("contend_grants", grant_log.size(), 32'd2);
        chk("contend_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);
        chk("contend_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 32'd1);
        chk("contend_done1",  (done_log.size() > 1) ? done_log[1] : -1, 32'd1);
        chk("contend_rx0", (rx_log.size() > 0) ? {24'd0, rx_log[0]} : 32'hFFFF, 32'h11);
        chk("contend_rx1", (rx_log.size() > 1) ? {24'd0, rx_log[1]} : 32'hFFFF, 32'h22);
        chk("contend_err", {31'd0, err}, 32'd0);

        // Fairness: both keep requesting
        clear_logs();
        rq[0].push_back(8'h01);
        rq[0].push_back(8'h02);
        rq[1].push_back(8'h03);
        rq[1].push_back(8'h04);
        drain(6000, "fair_drain");
        chk("fair_grants", grant_log.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("fair_order", (grant_log.size() > i) ? grant_log[i] : -1, i % 2);

        // Start timeout with the transmitter stubbed idle
        clear_logs();
        stub       = 1'b1;
        start_fell = 1'b0;
        rq[1].push_back(8'h5A);
        n = 0;
        while (!start_fell && n < 600) begin
            step();
            n++;
        end
        chk("timeout_start_fell", {31'd0, start_fell}, 32'd1);
        chk("timeout_start_len", last_run, START_TIMEOUT);
        chk("timeout_err_set", {31'd0, err}, 32'd1);
        pending = 1'b0;
        dc      = done_cnt;
        repeat (8) step();
        chk("timeout_no_done", done_cnt, dc);
        stub = 1'b0;
        rq[0].push_back(8'h96);
        drain(3000, "timeout_recover_drain");
        chk("timeout_recover_rx", (rx_log.size() > 0) ? {24'd0, rx_log[$]} : 32'hFFFF, 32'h96);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reset during data bit 3 of 0xF0
        clear_logs();
        rq[0].push_back(8'hF0);
        n = 0;
        while (!pending && n < 200) begin
            step();
            n++;
        end
        chk("midrst_granted", {31'd0, pending}, 32'd1);
        rq[1].push_back(8'h3C);
        n = 0;
        while (rx_bit_idx != 3 && n < 1000) begin
            step();
            n++;
        end
        chk("midrst_reached_bit3", rx_bit_idx, 32'd3);
        do_reset();
        drain(4000, "midrst_drain");
        chk("midrst_rx_cnt", rx_log.size(), 32'd2);
        chk("midrst_rx0", (rx_log.size() > 0) ? {24'd0, rx_log[0]} : 32'hFFFF, 32'hF0);
        chk("midrst_rx1", (rx_log.size() > 1) ? {24'd0, rx_log[1]} : 32'hFFFF, 32'h3C);
        chk("midrst_done_cnt", done_cnt, 32'd1);

        // Randomised traffic with random gaps
        clear_logs();
        for (int i = 0; i < 24; i++) begin
            rq[$urandom_range(0, NUM_REQ - 1)].push_back(8'($urandom));
            repeat ($urandom_range(0, 120)) step();
        end
        drain(20000, "random_drain");
        chk("random_rx_cnt", rx_log.size(), 32'd24);
        chk("random_done_cnt", done_cnt, 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
